// File: rtl/request_collector_pkg.sv
// Shared constants and FSM encoding for the request collector.
package request_collector_pkg;

    localparam int N    = 8;
    localparam int IDXW = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/request_collector_lowest_bit_index.sv
// Priority encoder: index of the lowest set bit of an N-bit vector.
module lowest_bit_index #(
    parameter int N    = request_collector_pkg::N,
    parameter int IDXW = request_collector_pkg::IDXW
) (
    input  logic [N-1:0]    vec_i,
    output logic [IDXW-1:0] idx_o,
    output logic            valid_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDXW'(i);
            end
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/request_collector.sv
// Collects single-cycle client requests into a sticky pending vector and
// runs one service at a time on a shared resource, chosen by an external arbiter.
//
// state    | meaning
// ST_IDLE  | no service in flight; waiting for a qualifying grant
// ST_ISSUE | start pulse out for start_idx
// ST_WAIT  | waiting for done from the shared resource
module request_collector #(
    parameter int N    = request_collector_pkg::N,
    parameter int IDXW = request_collector_pkg::IDXW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    pending,
    input  logic [N-1:0]    grant,
    output logic            start,
    output logic [IDXW-1:0] start_idx,
    output logic            busy,
    input  logic            done,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    overflow
);
    import request_collector_pkg::*;

    state_e          state_q;
    logic [N-1:0]    pending_q;
    logic [N-1:0]    pending_d;
    logic [N-1:0]    ack_q;
    logic [N-1:0]    overflow_q;
    logic [N-1:0]    overflow_d;
    logic [N-1:0]    clear_vec;
    logic [N-1:0]    grant_eligible;
    logic            start_q;
    logic            busy_q;
    logic [IDXW-1:0] start_idx_q;
    logic [IDXW-1:0] sel_idx;
    logic            sel_valid;

    // Grants for clients with nothing pending are meaningless and dropped here.
    assign grant_eligible = grant & pending_q;

    lowest_bit_index #(
        .N    (N),
        .IDXW (IDXW)
    ) u_sel (
        .vec_i   (grant_eligible),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // A new request on the clearing edge re-arms the bit (set wins) and is not an overflow.
    always_comb begin
        clear_vec = '0;
        if (state_q == ST_WAIT && done) begin
            clear_vec[start_idx_q] = 1'b1;
        end
        pending_d  = (pending_q & ~clear_vec) | req;
        overflow_d = req & pending_q & ~clear_vec;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= '0;
            ack_q      <= '0;
            overflow_q <= '0;
        end else begin
            pending_q  <= pending_d;
            ack_q      <= clear_vec;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            start_idx_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state_q     <= ST_ISSUE;
                        start_idx_q <= sel_idx;
                        start_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pending   = pending_q;
    assign start     = start_q;
    assign start_idx = start_idx_q;
    assign busy      = busy_q;
    assign ack       = ack_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_request_collector.sv
// Self-checking bench for request_collector: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_request_collector;
    localparam int N    = 8;
    localparam int IDXW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    grant = '0;
    logic            done = 1'b0;
    logic [N-1:0]    pending;
    logic            start;
    logic [IDXW-1:0] start_idx;
    logic            busy;
    logic [N-1:0]    ack;
    logic [N-1:0]    overflow;

    int checks = 0;
    int failures = 0;

    // Reference model: set of outstanding requests plus the one service in flight.
    logic [N-1:0] m_pend;
    bit           m_busy;
    bit           m_fresh;
    int           m_idx;
    logic [N-1:0] e_ack;
    logic [N-1:0] e_ovf;
    bit           e_start;

    int           order[$];
    int           ack_cnt[N];
    logic [N-1:0] ovf_seen;

    always #5 clk = ~clk;

    request_collector #(.N(N), .IDXW(IDXW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .pending   (pending),
        .grant     (grant),
        .start     (start),
        .start_idx (start_idx),
        .busy      (busy),
        .done      (done),
        .ack       (ack),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] lowbit(input logic [N-1:0] v);
        return v & (~v + 1'b1);
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_busy  = 0;
        m_fresh = 0;
        m_idx   = 0;
        e_ack   = '0;
        e_ovf   = '0;
        e_start = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] g, input logic d);
        logic [N-1:0] q;
        e_ack   = (m_busy && !m_fresh && d) ? (N'(1) << m_idx) : '0;
        e_ovf   = r & m_pend & ~e_ack;
        e_start = 0;
        if (!m_busy) begin
            q = g & m_pend;
            if (q != '0) begin
                m_idx = 0;
                while (!q[m_idx]) m_idx++;
                m_busy  = 1;
                m_fresh = 1;
                e_start = 1;
            end
        end else if (m_fresh) begin
            m_fresh = 0;
        end else if (d) begin
            m_busy = 0;
        end
        m_pend = (m_pend & ~e_ack) | r;
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".pending"},   pending,   m_pend);
        check({ctx, ".start"},     start,     e_start);
        check({ctx, ".start_idx"}, start_idx, m_idx);
        check({ctx, ".busy"},      busy,      m_busy);
        check({ctx, ".ack"},       ack,       e_ack);
        check({ctx, ".overflow"},  overflow,  e_ovf);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] g, input logic d);
        req   = r;
        grant = g;
        done  = d;
        @(posedge clk);
        model_step(r, g, d);
        #1;
        check_all("cyc");
        if (start === 1'b1) order.push_back(int'(start_idx));
        for (int i = 0; i < N; i++) if (ack[i] === 1'b1) ack_cnt[i]++;
        ovf_seen = ovf_seen | overflow;
        @(negedge clk);
    endtask

    task automatic do_reset();
        req   = '0;
        grant = '0;
        done  = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] g;
        logic         d;
        logic [N-1:0] multi;
        int           exp_order[5];

        @(negedge clk);

        // Single client end to end
        do_reset();
        cyc(8'h04, '0, 0);
        check("r032_pending", pending, 8'h04);
        cyc('0, 8'h04, 0);
        check("r032_start", start, 1'b1);
        check("r032_idx", start_idx, 3'd2);
        cyc('0, 8'h04, 0);
        cyc('0, 8'h04, 1);
        check("r032_ack", ack, 8'h04);
        check("r032_pend_clr", pending, 8'h00);
        cyc('0, '0, 0);
        check("r032_ack_once", ack, 8'h00);

        // Five clients drained by a lowest-bit-first arbiter
        do_reset();
        order.delete();
        foreach (ack_cnt[i]) ack_cnt[i] = 0;
        ovf_seen = '0;
        multi = 8'hAB;
        cyc(multi, '0, 0);
        for (int k = 0; k < 60 && (m_pend != '0 || m_busy); k++) begin
            cyc('0, lowbit(m_pend), m_busy && !m_fresh);
        end
        check("r033_drained_pend", pending, 8'h00);
        check("r033_drained_busy", busy, 1'b0);
        exp_order = '{0, 1, 3, 5, 7};
        check("r033_order_len", order.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("r033_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
        end
        for (int i = 0; i < N; i++) begin
            check("r033_ack_cnt", ack_cnt[i], int'(multi[i]));
        end
        check("r033_no_ovf", ovf_seen, 8'h00);

        // Re-request while pending
        do_reset();
        cyc(8'h08, '0, 0);
        cyc(8'h08, '0, 0);
        check("r034_ovf", overflow, 8'h08);
        check("r034_pend", pending, 8'h08);
        cyc('0, '0, 0);
        check("r034_ovf_once", overflow, 8'h00);

        // Re-request on the clearing edge
        do_reset();
        cyc(8'h04, '0, 0);
        cyc('0, 8'h04, 0);
        cyc('0, 8'h04, 0);
        cyc(8'h04, 8'h04, 1);
        check("r035_ack", ack, 8'h04);
        check("r035_pend", pending, 8'h04);
        check("r035_ovf", overflow, 8'h00);
        cyc('0, 8'h04, 0);
        check("r035_restart", start, 1'b1);
        check("r035_idx", start_idx, 3'd2);

        // Reset during WAIT
        do_reset();
        cyc(8'h20, '0, 0);
        cyc('0, 8'h20, 0);
        check("r036_idx", start_idx, 3'd5);
        cyc('0, 8'h20, 0);
        check("r036_busy", busy, 1'b1);
        do_reset();
        cyc('0, '0, 1);
        check("r036_no_ack", ack, 8'h00);
        check("r036_idle", busy, 1'b0);

        // Non-qualifying grant, stray done
        do_reset();
        cyc(8'h01, '0, 0);
        cyc('0, 8'h10, 0);
        check("r037_no_start", start, 1'b0);
        check("r037_no_busy", busy, 1'b0);
        cyc('0, '0, 1);
        check("r037_no_ack", ack, 8'h00);
        check("r037_pend", pending, 8'h01);

        // Random traffic
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
                case ($urandom_range(0, 3))
                    0, 1:    g = lowbit(m_pend);
                    2:       g = N'($urandom);
                    default: g = '0;
                endcase
                d = ($urandom_range(0, 2) == 0);
                cyc(r, g, d);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/request_collector.md
REQUEST_COLLECTOR -- requirements
Module: request_collector

Interface
REQ-001 The block SHALL have parameter N, default 8, number of client request lines.
REQ-002 The block SHALL have parameter IDXW, default 3, width of client index (log2 N).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req, input, N, per-client single-cycle request pulses.
REQ-006 The block SHALL have port pending, output, N, registered sticky request vector, driven to the external priority arbiter input.
REQ-007 The block SHALL have port grant, input, N, one-hot-or-zero grant from that arbiter.
REQ-008 The block SHALL have port start, output, 1, one-cycle pulse launching service for the selected client.
REQ-009 The block SHALL have port start_idx, output, IDXW, index of the client being serviced; stable while busy.
REQ-010 The block SHALL have port busy, output, 1, high in ISSUE and WAIT.
REQ-011 The block SHALL have port done, input, 1, single-cycle service-complete pulse from the shared resource.
REQ-012 The block SHALL have port ack, output, N, one-cycle completion pulse to the serviced client.
REQ-013 The block SHALL have port overflow, output, N, one-cycle pulse when a request is dropped.

Function
REQ-014 A req[i] pulse sampled at edge t SHALL set pending[i], visible after edge t.
REQ-015 req[i] while pending[i] is set and not being cleared SHALL be dropped and SHALL pulse overflow[i] the next cycle.
REQ-016 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-017 IDLE: if (grant & pending) is nonzero, the lowest set bit of (grant & pending) SHALL be latched into start_idx and the FSM SHALL move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-018 Grant bits not set in pending SHALL be ignored; a multi-hot grant SHALL resolve to its lowest qualifying bit.
REQ-019 ISSUE SHALL assert start for exactly one cycle, then move to WAIT.
REQ-020 WAIT: on done=1, the next cycle SHALL clear pending[start_idx], pulse ack[start_idx] and return to IDLE.
REQ-021 done in IDLE or ISSUE SHALL be ignored.
REQ-022 Grant changes while busy SHALL NOT affect start_idx, and pending[start_idx] SHALL stay set until completion.
REQ-023 Latency SHALL be: req at edge t -> start high in the cycle after edge t+1 (two cycles); done at edge d -> ack high after edge d; earliest next start in the cycle after edge d+1.
REQ-024 If req[start_idx] coincides with the clearing edge, set SHALL win: pending stays 1, ack still pulses, no overflow.
REQ-025 Requests from other clients SHALL be accepted in every state.
REQ-026 At most one ack bit SHALL be high in any cycle; start and ack SHALL never be high in the same cycle.

Reset
REQ-027 reset SHALL asynchronously force IDLE, pending=0, start=0, start_idx=0, busy=0, ack=0, overflow=0.
REQ-028 Reset mid-service SHALL abandon the service without an ack; a later done SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold N, IDXW and the FSM state encoding (IDLE=0, ISSUE=1, WAIT=2).
REQ-030 One sub-module, lowest_bit_index, SHALL encode an N-bit vector to the IDXW index of its lowest set bit.
REQ-031 All outputs SHALL be registered; no combinational path from grant or done to any output.

Verification
REQ-032 Reset, then req=00000100 for one cycle -> pending=00000100; with grant=00000100, start pulses with start_idx=2; done -> ack=00000100, pending=0.
REQ-033 req=10101011 in one cycle with a lowest-bit-priority arbiter -> clients serviced in order 0,1,3,5,7, each acked once, no overflow.
REQ-034 req[3] pulsed again while pending[3]=1 -> overflow=00001000 for one cycle, pending unchanged.
REQ-035 req[2] on the same edge that pending[2] clears -> ack=00000100 and pending[2] stays 1, second service follows.
REQ-036 Assert reset during WAIT for idx 5 -> all outputs 0; subsequent done produces no ack.
REQ-037 grant=00010000 with pending=00000001 in IDLE -> no start; done pulse in IDLE -> no ack.
